// File: rtl/counter_to_10_monitor.sv
// counter_to_10_monitor
//
// Receiving end of a mod-10 up/down counter. Samples the counter's count and
// carry every clock, predicts the next count, flags mismatches and cascades
// the counter's carries/borrows into a BCD tens digit.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   en         in   monitor enable; low returns the monitor to IDLE
//   up_down    in   counter direction (1 = up, 0 = down)
//   count[3:0] in   counter value, legal 0..9
//   carry      in   counter terminal-count flag
//   tens[3:0]  out  BCD tens digit
//   tens_carry out  one-cycle pulse when tens wraps (9->0 up, 0->9 down)
//   locked     out  high while tracking the counter
//   err        out  one-cycle pulse per detected mismatch
//   err_count  out  total errors, saturating at 255
//   fault      out  high while in the sticky FAULT state
//
// Handshake: none. Every input is sampled at every rising edge while en is
// high; there is no valid/ready pairing, the counter is assumed to advance
// exactly once per clock.
//
// The FSM state is held in the enum register 'state' for checkers to bind to.

module counter_to_10_monitor #(
  parameter int MAX_ERR = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       up_down,
  input  logic [3:0] count,
  input  logic       carry,
  output logic [3:0] tens,
  output logic       tens_carry,
  output logic       locked,
  output logic       err,
  output logic [7:0] err_count,
  output logic       fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [7:0] MAX_ERR_B = 8'(MAX_ERR);

  state_t     state;
  logic [3:0] exp_cnt;

  logic       count_legal;
  logic       carry_exp;
  logic [3:0] next_cnt;
  logic       mismatch;
  logic       sample_err;
  logic [7:0] err_inc;
  logic [3:0] tens_next;
  logic       tens_wrap;

  // The prediction always uses up_down from the same cycle as the count,
  // so a direction reversal is legal on any cycle.
  always_comb begin
    count_legal = (count <= 4'd9);
    carry_exp   = up_down ? (count == 4'd9) : (count == 4'd0);

    next_cnt = 4'd0;
    if (up_down) next_cnt = (count == 4'd9) ? 4'd0 : count + 4'd1;
    else         next_cnt = (count == 4'd0) ? 4'd9 : count - 4'd1;

    mismatch = !count_legal || (count != exp_cnt) || (carry != carry_exp);

    sample_err = ((state == SYNC) && !count_legal) ||
                 ((state == TRACK) && mismatch);

    err_inc = (err_count == 8'hFF) ? 8'hFF : err_count + 8'd1;

    tens_next = 4'd0;
    if (up_down) tens_next = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
    else         tens_next = (tens == 4'd0) ? 4'd9 : tens - 4'd1;
    tens_wrap = up_down ? (tens == 4'd9) : (tens == 4'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      exp_cnt    <= 4'd0;
      tens       <= 4'd0;
      tens_carry <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_count  <= 8'd0;
      fault      <= 1'b0;
    end else begin
      // Pulses default low every cycle.
      err        <= 1'b0;
      tens_carry <= 1'b0;

      if (!en) begin
        // tens and err_count survive a disable; only reset clears them.
        state  <= IDLE;
        locked <= 1'b0;
        fault  <= 1'b0;
      end else if (sample_err) begin
        // An error wins over a coincident carry: tens is left untouched.
        err       <= 1'b1;
        err_count <= err_inc;
        locked    <= 1'b0;
        if (err_inc >= MAX_ERR_B) begin
          state <= FAULT;
          fault <= 1'b1;
        end else begin
          state <= SYNC;
        end
      end else begin
        unique case (state)
          IDLE: begin
            state <= SYNC;
          end
          SYNC: begin
            // Carry seen while synchronising is not cascaded into tens.
            exp_cnt <= next_cnt;
            state   <= TRACK;
            locked  <= 1'b1;
          end
          TRACK: begin
            exp_cnt <= next_cnt;
            if (carry) begin
              tens       <= tens_next;
              tens_carry <= tens_wrap;
            end
          end
          FAULT: begin
            // Sticky: hold everything until en drops or reset.
            state <= FAULT;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_counter_to_10_monitor.sv
// Directed testbench for counter_to_10_monitor. A small model of a correct
// mod-10 counter drives count/carry; scenario tasks override it to inject
// faults and compare the monitor's outputs against hand-computed values.

module tb_counter_to_10_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       up_down;
  logic [3:0] count;
  logic       carry;
  logic [3:0] tens;
  logic       tens_carry;
  logic       locked;
  logic       err;
  logic [7:0] err_count;
  logic       fault;

  int errors = 0;
  int checks = 0;
  int c = 0;            // value the model counter is currently driving
  int err_pulses = 0;
  int tc_pulses = 0;

  counter_to_10_monitor #(.MAX_ERR(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .up_down    (up_down),
    .count      (count),
    .carry      (carry),
    .tens       (tens),
    .tens_carry (tens_carry),
    .locked     (locked),
    .err        (err),
    .err_count  (err_count),
    .fault      (fault)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Driver tasks
  task automatic apply();
    count = 4'(c);
    carry = up_down ? (c == 9) : (c == 0);
  endtask

  // One clock: outputs are observed 1 ns after the rising edge, then the
  // model counter advances (if requested) and drives its next value.
  task automatic step(input bit advance);
    @(posedge clk);
    #1;
    if (err) err_pulses++;
    if (tens_carry) tc_pulses++;
    if (advance) c = up_down ? (c + 1) % 10 : (c + 9) % 10;
    apply();
  endtask

  // Scenarios
  task automatic test_reset();
    reset = 1'b0; en = 1'b0; up_down = 1'b1; c = 0; apply();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (tens !== 4'd0) begin errors++; $display("FAIL reset_tens: got %0d want 0", tens); end
    checks++; if (tens_carry !== 1'b0) begin errors++; $display("FAIL reset_tens_carry: got %0b want 0", tens_carry); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b want 0", locked); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", err); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %0b want 0", fault); end
    reset = 1'b1;
    step(1'b0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL idle_locked: got %0b want 0", locked); end
  endtask

  task automatic test_lock_up();
    err_pulses = 0; tc_pulses = 0;
    en = 1'b1; up_down = 1'b1; c = 0; apply();
    step(1'b1);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_edge1: got %0b want 0", locked); end
    step(1'b1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_edge2: got %0b want 1", locked); end
    repeat (8) step(1'b1);
    checks++; if (tens !== 4'd1) begin errors++; $display("FAIL up_tens_10: got %0d want 1", tens); end
    repeat (90) step(1'b1);
    checks++; if (tens !== 4'd0) begin errors++; $display("FAIL up_tens_100: got %0d want 0", tens); end
    checks++; if (tc_pulses !== 1) begin errors++; $display("FAIL up_tens_carry_pulses: got %0d want 1", tc_pulses); end
    checks++; if (err_pulses !== 0) begin errors++; $display("FAIL up_err_pulses: got %0d want 0", err_pulses); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL up_locked: got %0b want 1", locked); end
  endtask

  task automatic test_down();
    en = 1'b0;
    step(1'b0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL disable_locked: got %0b want 0", locked); end
    up_down = 1'b0; c = 5; apply(); en = 1'b1;
    step(1'b0);                       // IDLE -> SYNC
    err_pulses = 0; tc_pulses = 0;
    step(1'b1);                       // SYNC samples 5
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL down_locked: got %0b want 1", locked); end
    repeat (6) step(1'b1);            // samples 4,3,2,1,0,9
    checks++; if (tens !== 4'd9) begin errors++; $display("FAIL down_tens: got %0d want 9", tens); end
    checks++; if (tc_pulses !== 1) begin errors++; $display("FAIL down_tens_carry_pulses: got %0d want 1", tc_pulses); end
    checks++; if (err_pulses !== 0) begin errors++; $display("FAIL down_err_pulses: got %0d want 0", err_pulses); end
  endtask

  task automatic test_skip();
    up_down = 1'b1; apply();          // reversal: model now at 8, counting up
    for (int i = 0; i < 20; i++) begin
      if (c == 5) break;
      step(1'b1);
    end
    checks++; if (c != 5) begin errors++; $display("FAIL skip_reach: got %0d want 5", c); end
    count = 4'd7; carry = 1'b0;
    step(1'b1);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL skip_err: got %0b want 1", err); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL skip_err_count: got %0d want 1", err_count); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL skip_unlocked: got %0b want 0", locked); end
    step(1'b1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL skip_relock: got %0b want 1", locked); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL skip_err_once: got %0b want 0", err); end
    step(1'b1);
    checks++; if (err !== 1'b0 || locked !== 1'b1) begin errors++; $display("FAIL skip_track: got err=%0b locked=%0b want 0/1", err, locked); end
  endtask

  task automatic test_carry_fault();
    for (int i = 0; i < 20; i++) begin
      if (c == 4) break;
      step(1'b1);
    end
    checks++; if (tens !== 4'd1) begin errors++; $display("FAIL cf_tens_before: got %0d want 1", tens); end
    carry = 1'b1;                     // count is 4, contract says carry 0
    step(1'b1);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL cf_err: got %0b want 1", err); end
    checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL cf_err_count: got %0d want 2", err_count); end
    checks++; if (tens !== 4'd1) begin errors++; $display("FAIL cf_tens_held: got %0d want 1", tens); end
    checks++; if (tens_carry !== 1'b0) begin errors++; $display("FAIL cf_tens_carry: got %0b want 0", tens_carry); end
    step(1'b1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL cf_relock: got %0b want 1", locked); end
  endtask

  task automatic test_fault_threshold();
    reset = 1'b0; #1; reset = 1'b1;
    en = 1'b1; up_down = 1'b1; c = 0; apply();
    step(1'b0);                       // IDLE -> SYNC
    for (int i = 1; i <= 4; i++) begin
      count = 4'd12; carry = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL thr_err_%0d: got %0b want 1", i, err); end
      checks++; if (err_count !== 8'(i)) begin errors++; $display("FAIL thr_err_count_%0d: got %0d want %0d", i, err_count, i); end
      checks++; if (fault !== (i == 4)) begin errors++; $display("FAIL thr_fault_%0d: got %0b want %0b", i, fault, (i == 4)); end
    end
    c = 0; apply();
    step(1'b0);
    step(1'b0);
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_held: got %0b want 1", fault); end
    checks++; if (err_count !== 8'd4) begin errors++; $display("FAIL fault_err_count_held: got %0d want 4", err_count); end
    checks++; if (err !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL fault_quiet: got err=%0b locked=%0b want 0/0", err, locked); end
    en = 1'b0;
    step(1'b0);
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_exit: got %0b want 0", fault); end
    checks++; if (err_count !== 8'd4) begin errors++; $display("FAIL fault_exit_err_count: got %0d want 4", err_count); end
  endtask

  task automatic test_async_reset();
    en = 1'b1; up_down = 1'b1; c = 0; apply();
    step(1'b0);                       // IDLE -> SYNC
    repeat (36) step(1'b1);           // carries at samples 9,19,29; now driving 6
    checks++; if (tens !== 4'd3) begin errors++; $display("FAIL ar_tens_before: got %0d want 3", tens); end
    checks++; if (err_count !== 8'd4) begin errors++; $display("FAIL ar_err_count_before: got %0d want 4", err_count); end
    #2 reset = 1'b0;
    #1;
    checks++; if (tens !== 4'd0 || locked !== 1'b0 || err_count !== 8'd0) begin errors++; $display("FAIL ar_immediate: got tens=%0d locked=%0b err_count=%0d want 0/0/0", tens, locked, err_count); end
    checks++; if (err !== 1'b0 || fault !== 1'b0 || tens_carry !== 1'b0) begin errors++; $display("FAIL ar_immediate_flags: got err=%0b fault=%0b tens_carry=%0b want 0/0/0", err, fault, tens_carry); end
    #2 reset = 1'b1;
    step(1'b1);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL ar_relock_edge1: got %0b want 0", locked); end
    step(1'b1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL ar_relock_edge2: got %0b want 1", locked); end
    checks++; if (err !== 1'b0 || tens !== 4'd0) begin errors++; $display("FAIL ar_relock_clean: got err=%0b tens=%0d want 0/0", err, tens); end
  endtask

  // Sequence and report
  initial begin
    test_reset();
    test_lock_up();
    test_down();
    test_skip();
    test_carry_fault();
    test_fault_threshold();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
